// File: rtl/wr_burst_sched.sv
// Two-channel round-robin write-burst scheduler feeding wr_ctrl from FWFT pixel FIFOs,
// with per-channel ping-pong frame buffers and completed-buffer reporting.
`timescale 1ns/1ps
module wr_burst_sched #(
  parameter int                         CTRL_ADDR_WIDTH = 28,
  parameter int                         MEM_DQ_WIDTH    = 16,
  parameter int                         BURST_LEN       = 16,
  parameter int                         ADDR_STEP       = 128,
  parameter int                         FRAME_BURSTS    = 900,
  parameter logic [CTRL_ADDR_WIDTH-1:0] FRAME_STRIDE    = 28'h0100000,
  parameter logic [CTRL_ADDR_WIDTH-1:0] CH0_BASE        = 28'h0000000,
  parameter logic [CTRL_ADDR_WIDTH-1:0] CH1_BASE        = 28'h0400000,
  parameter int                         CNT_W           = 10
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ch0_frame_start,
  input  logic [CNT_W-1:0]             ch0_fifo_cnt,
  input  logic [MEM_DQ_WIDTH*8-1:0]    ch0_rd_data,
  output logic                         ch0_rd_en,
  output logic                         ch0_done_buf,
  output logic                         ch0_frame_drop,
  input  logic                         ch1_frame_start,
  input  logic [CNT_W-1:0]             ch1_fifo_cnt,
  input  logic [MEM_DQ_WIDTH*8-1:0]    ch1_rd_data,
  output logic                         ch1_rd_en,
  output logic                         ch1_done_buf,
  output logic                         ch1_frame_drop,
  output logic                         wr_en,
  output logic [CTRL_ADDR_WIDTH-1:0]   wr_addr,
  output logic [3:0]                   wr_id,
  output logic [3:0]                   wr_len,
  input  logic                         wr_ready,
  output logic [MEM_DQ_WIDTH*8-1:0]    wr_data
);

  localparam int AW   = CTRL_ADDR_WIDTH;
  localparam int BC_W = $clog2(FRAME_BURSTS);

  typedef enum logic [1:0] {IDLE, ARB, CMD, DATA} state_t;

  state_t             state_q, state_d;
  logic               grant_q, grant_d, rr_q, rr_d;
  logic [4:0]         beat_cnt_q, beat_cnt_d;
  logic               wr_en_q, wr_en_d;
  logic [AW-1:0]      wr_addr_q, wr_addr_d;
  logic [3:0]         wr_id_q, wr_id_d;
  logic [1:0]         active_q, active_d, wbuf_q, wbuf_d, done_q, done_d;
  logic [1:0]         pend_q, pend_d, drop_q, drop_d;
  logic [BC_W-1:0]    burst_cnt_q [2];
  logic [BC_W-1:0]    burst_cnt_d [2];
  logic [AW-1:0]      addr_q [2];
  logic [AW-1:0]      addr_d [2];
  logic [1:0]         elig_s, start_s, busy_s;
  logic               pop_s, burst_end_s, sel_s;

  function automatic logic [AW-1:0] buf_base(input logic ch, input logic wb);
    logic [AW-1:0] b;
    b = ch ? CH1_BASE : CH0_BASE;
    buf_base = wb ? (b + FRAME_STRIDE) : b;
  endfunction

  assign elig_s[0] = active_q[0] && (ch0_fifo_cnt >= CNT_W'(BURST_LEN));
  assign elig_s[1] = active_q[1] && (ch1_fifo_cnt >= CNT_W'(BURST_LEN));
  assign start_s   = {ch1_frame_start, ch0_frame_start};
  // A channel is busy from its command strobe until its last beat; starts then wait.
  assign busy_s    = ((state_q == CMD) || (state_q == DATA)) ? (grant_q ? 2'b10 : 2'b01) : 2'b00;

  assign wr_en          = wr_en_q;
  assign wr_addr        = wr_addr_q;
  assign wr_id          = wr_id_q;
  assign wr_len         = 4'(BURST_LEN - 1);
  assign wr_data        = grant_q ? ch1_rd_data : ch0_rd_data;
  assign ch0_rd_en      = pop_s & ~grant_q;
  assign ch1_rd_en      = pop_s & grant_q;
  assign ch0_done_buf   = done_q[0];
  assign ch1_done_buf   = done_q[1];
  assign ch0_frame_drop = drop_q[0];
  assign ch1_frame_drop = drop_q[1];

  // Next-state: arbitration FSM, burst bookkeeping, then frame-start handling.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_d        = rr_q;
    beat_cnt_d  = beat_cnt_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_id_d     = wr_id_q;
    active_d    = active_q;
    wbuf_d      = wbuf_q;
    done_d      = done_q;
    pend_d      = pend_q;
    drop_d      = 2'b00;
    burst_cnt_d = burst_cnt_q;
    addr_d      = addr_q;
    pop_s       = 1'b0;
    burst_end_s = 1'b0;
    sel_s       = grant_q;
    case (state_q)
      IDLE: begin
        if (|elig_s) state_d = ARB;
        else         state_d = IDLE;
      end
      ARB: begin
        if (|elig_s) begin
          if (elig_s[~rr_q]) sel_s = ~rr_q;
          else               sel_s = rr_q;
          grant_d   = sel_s;
          rr_d      = sel_s;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q[sel_s];
          wr_id_d   = {3'b000, sel_s};
          state_d   = CMD;
        end else begin
          state_d = IDLE;
        end
      end
      CMD: begin
        beat_cnt_d = 5'd0;
        state_d    = DATA;
      end
      DATA: begin
        if (wr_ready && (beat_cnt_q < 5'(BURST_LEN))) begin
          pop_s      = 1'b1;
          beat_cnt_d = beat_cnt_q + 5'd1;
          if (beat_cnt_q == 5'(BURST_LEN - 1)) begin
            burst_end_s          = 1'b1;
            state_d              = IDLE;
            addr_d[grant_q]      = addr_q[grant_q] + AW'(ADDR_STEP);
            burst_cnt_d[grant_q] = burst_cnt_q[grant_q] + BC_W'(1);
            if (burst_cnt_q[grant_q] == BC_W'(FRAME_BURSTS - 1)) begin
              done_d[grant_q]   = wbuf_q[grant_q];
              active_d[grant_q] = 1'b0;
            end else begin
              done_d[grant_q]   = done_q[grant_q];
            end
          end else begin
            state_d = DATA;
          end
        end else begin
          state_d = DATA;
        end
      end
      default: state_d = IDLE;
    endcase
    // Uses done_d/active_d so a start on the final beat sees the completed frame.
    for (int ch = 0; ch < 2; ch++) begin
      if (busy_s[ch] && !burst_end_s) begin
        pend_d[ch] = pend_q[ch] | start_s[ch];
      end else if (start_s[ch] || pend_q[ch]) begin
        drop_d[ch]      = active_d[ch];
        wbuf_d[ch]      = ~done_d[ch];
        burst_cnt_d[ch] = '0;
        addr_d[ch]      = buf_base(1'(ch), ~done_d[ch]);
        active_d[ch]    = 1'b1;
        pend_d[ch]      = 1'b0;
      end else begin
        pend_d[ch] = pend_q[ch];
      end
    end
  end

  // State and registered outputs; reset abandons any burst in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      grant_q        <= 1'b0;
      rr_q           <= 1'b0;
      beat_cnt_q     <= 5'd0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_id_q        <= 4'd0;
      active_q       <= 2'b00;
      wbuf_q         <= 2'b00;
      done_q         <= 2'b11;
      pend_q         <= 2'b00;
      drop_q         <= 2'b00;
      burst_cnt_q[0] <= '0;
      burst_cnt_q[1] <= '0;
      addr_q[0]      <= '0;
      addr_q[1]      <= '0;
    end else begin
      state_q        <= state_d;
      grant_q        <= grant_d;
      rr_q           <= rr_d;
      beat_cnt_q     <= beat_cnt_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_id_q        <= wr_id_d;
      active_q       <= active_d;
      wbuf_q         <= wbuf_d;
      done_q         <= done_d;
      pend_q         <= pend_d;
      drop_q         <= drop_d;
      burst_cnt_q[0] <= burst_cnt_d[0];
      burst_cnt_q[1] <= burst_cnt_d[1];
      addr_q[0]      <= addr_d[0];
      addr_q[1]      <= addr_d[1];
    end
  end

endmodule

// File: tb/tb_wr_burst_sched.sv
// Scoreboard bench for wr_burst_sched: stimulus pushes expected commands/beats,
// a negedge monitor pops and compares whenever the DUT strobes wr_en or rd_en.
`timescale 1ns/1ps
module tb_wr_burst_sched;
  localparam int AW = 28;
  localparam int DW = 128;
  localparam int CW = 10;
  localparam int BL = 16;

  typedef struct packed { logic [AW-1:0] addr; logic [3:0] id; } cmd_t;
  typedef struct packed { logic ch; logic [DW-1:0] data; } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          ch0_frame_start, ch1_frame_start;
  logic [CW-1:0] ch0_fifo_cnt, ch1_fifo_cnt;
  logic [DW-1:0] ch0_rd_data, ch1_rd_data, wr_data;
  logic          ch0_rd_en, ch1_rd_en, ch0_done_buf, ch1_done_buf;
  logic          ch0_frame_drop, ch1_frame_drop;
  logic          wr_en, wr_ready;
  logic [AW-1:0] wr_addr;
  logic [3:0]    wr_id, wr_len;

  logic [15:0] loaded0, loaded1;
  logic [15:0] popped0 = 16'd0;
  logic [15:0] popped1 = 16'd0;
  logic [15:0] exp_pop [2];
  logic        ready_fix, tog_en;
  logic        tog_q = 1'b0;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          drops0  = 0;
  int          drops1  = 0;
  cmd_t        cmd_q [$];
  beat_t       beat_q [$];
  cmd_t        mc;
  beat_t       mb;

  function automatic logic [DW-1:0] word(input logic ch, input logic [15:0] k);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1 -: 16] = 16'hA5A5 ^ k;
    w[16]         = ch;
    w[15:0]       = k;
    return w;
  endfunction

  assign ch0_fifo_cnt = CW'(loaded0 - popped0);
  assign ch1_fifo_cnt = CW'(loaded1 - popped1);
  assign ch0_rd_data  = word(1'b0, popped0);
  assign ch1_rd_data  = word(1'b1, popped1);
  assign wr_ready     = tog_en ? tog_q : ready_fix;

  wr_burst_sched #(.FRAME_BURSTS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .ch0_frame_start(ch0_frame_start), .ch0_fifo_cnt(ch0_fifo_cnt), .ch0_rd_data(ch0_rd_data),
    .ch0_rd_en(ch0_rd_en), .ch0_done_buf(ch0_done_buf), .ch0_frame_drop(ch0_frame_drop),
    .ch1_frame_start(ch1_frame_start), .ch1_fifo_cnt(ch1_fifo_cnt), .ch1_rd_data(ch1_rd_data),
    .ch1_rd_en(ch1_rd_en), .ch1_done_buf(ch1_done_buf), .ch1_frame_drop(ch1_frame_drop),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_id(wr_id), .wr_len(wr_len),
    .wr_ready(wr_ready), .wr_data(wr_data)
  );

  // FWFT FIFO model: the head word advances on each pop.
  always @(posedge clk) begin
    if (ch0_rd_en) popped0 <= popped0 + 16'd1;
    if (ch1_rd_en) popped1 <= popped1 + 16'd1;
    tog_q <= ~tog_q;
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_burst(input logic ch, input logic [AW-1:0] addr);
    cmd_t c;
    beat_t b;
    c.addr = addr;
    c.id   = {3'b000, ch};
    cmd_q.push_back(c);
    for (int i = 0; i < BL; i++) begin
      b.ch   = ch;
      b.data = word(ch, exp_pop[ch]);
      beat_q.push_back(b);
      exp_pop[ch] = exp_pop[ch] + 16'd1;
    end
  endtask

  // Monitor: compares every command and every beat against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        if (cmd_q.size() == 0) begin
          check("unexpected_cmd", DW'(1), DW'(0));
        end else begin
          mc = cmd_q.pop_front();
          check("cmd_addr", DW'(wr_addr), DW'(mc.addr));
          check("cmd_id", DW'(wr_id), DW'(mc.id));
          check("cmd_len", DW'(wr_len), DW'(4'd15));
        end
      end
      if (ch0_rd_en || ch1_rd_en) begin
        check("pop_both_ch", DW'(ch0_rd_en & ch1_rd_en), DW'(0));
        check("pop_without_ready", DW'(wr_ready), DW'(1));
        if (beat_q.size() == 0) begin
          check("unexpected_pop", DW'(1), DW'(0));
        end else begin
          mb = beat_q.pop_front();
          check("beat_ch", DW'(ch1_rd_en), DW'(mb.ch));
          check("beat_data", wr_data, mb.data);
        end
      end
      if (ch0_frame_drop) drops0++;
      if (ch1_frame_drop) drops1++;
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    ch0_frame_start = 1'b0;
    ch1_frame_start = 1'b0;
    tog_en = 1'b0;
    ready_fix = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic s0, input logic s1);
    ch0_frame_start = s0;
    ch1_frame_start = s1;
    @(posedge clk);
    #1;
    ch0_frame_start = 1'b0;
    ch1_frame_start = 1'b0;
  endtask

  task automatic wait_wr_en(input string name);
    bit found = 1'b0;
    for (int i = 0; i < 64 && !found; i++) begin
      @(negedge clk);
      if (wr_en) found = 1'b1;
    end
    if (!found) check(name, DW'(0), DW'(1));
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 2000 && (cmd_q.size() != 0 || beat_q.size() != 0); i++) @(negedge clk);
    if (cmd_q.size() != 0 || beat_q.size() != 0) begin
      check(name, DW'(cmd_q.size() + beat_q.size()), DW'(0));
      cmd_q.delete();
      beat_q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d1;
    rst_n = 1'b0;
    loaded0 = 16'd0;
    loaded1 = 16'd0;
    exp_pop[0] = 16'd0;
    exp_pop[1] = 16'd0;
    do_reset();
    check("rst_wr_en", DW'(wr_en), DW'(0));
    check("rst_wr_addr", DW'(wr_addr), DW'(0));
    check("rst_wr_id", DW'(wr_id), DW'(0));
    check("rst_done_buf", DW'({ch1_done_buf, ch0_done_buf}), DW'(2'b11));
    check("rst_rd_en", DW'({ch1_rd_en, ch0_rd_en}), DW'(0));

    // T1: single burst, latency eligible -> wr_en of two cycles
    push_burst(1'b0, 28'h0000000);
    pulse(1'b1, 1'b0);
    loaded0 = loaded0 + 16'd16;
    @(negedge clk); check("t1_lat_c0", DW'(wr_en), DW'(0));
    @(negedge clk); check("t1_lat_c1", DW'(wr_en), DW'(0));
    @(negedge clk); check("t1_lat_c2", DW'(wr_en), DW'(1));
    wait_drain("t1_drain");
    repeat (20) @(posedge clk);
    #1;

    // T2: round-robin 0,1,0,1 with simultaneous frame starts
    do_reset();
    push_burst(1'b0, 28'h0000000);
    push_burst(1'b1, 28'h0400000);
    push_burst(1'b0, 28'h0000080);
    push_burst(1'b1, 28'h0400080);
    pulse(1'b1, 1'b1);
    loaded0 = loaded0 + 16'd32;
    wait_wr_en("t2_first_cmd_timeout");
    @(posedge clk);
    #1 loaded1 = loaded1 + 16'd32;
    wait_drain("t2_drain");

    // T3: backpressure, ready toggling every cycle
    do_reset();
    push_burst(1'b0, 28'h0000000);
    pulse(1'b1, 1'b0);
    tog_en = 1'b1;
    loaded0 = loaded0 + 16'd16;
    wait_drain("t3_drain");
    tog_en = 1'b0;

    // T4: frame completion; restart timed onto the frame's final beat
    do_reset();
    d0 = drops0;
    pulse(1'b1, 1'b0);
    push_burst(1'b0, 28'h0000000);
    push_burst(1'b0, 28'h0000080);
    push_burst(1'b0, 28'h0000100);
    loaded0 = loaded0 + 16'd48;
    wait_drain("t4_drain_a");
    check("t4_done_before_last", DW'(ch0_done_buf), DW'(1));
    push_burst(1'b0, 28'h0000180);
    loaded0 = loaded0 + 16'd16;
    wait_wr_en("t4_last_cmd_timeout");
    @(posedge clk);
    repeat (15) @(posedge clk);
    #1 ch0_frame_start = 1'b1;
    @(posedge clk);
    #1 ch0_frame_start = 1'b0;
    wait_drain("t4_drain_b");
    check("t4_done_frame0", DW'(ch0_done_buf), DW'(0));
    check("t4_no_drop", DW'(drops0 - d0), DW'(0));
    push_burst(1'b0, 28'h0100000);
    push_burst(1'b0, 28'h0100080);
    push_burst(1'b0, 28'h0100100);
    push_burst(1'b0, 28'h0100180);
    loaded0 = loaded0 + 16'd64;
    wait_drain("t4_drain_c");
    check("t4_done_frame1", DW'(ch0_done_buf), DW'(1));
    check("t4_ch1_done", DW'(ch1_done_buf), DW'(1));

    // T5: start mid-burst -> drop after burst, restart at buffer base
    do_reset();
    d0 = drops0;
    pulse(1'b1, 1'b0);
    push_burst(1'b0, 28'h0000000);
    loaded0 = loaded0 + 16'd16;
    wait_wr_en("t5_cmd_timeout");
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1 ch0_frame_start = 1'b1;
    @(posedge clk);
    #1 ch0_frame_start = 1'b0;
    check("t5_no_drop_mid_burst", DW'(drops0 - d0), DW'(0));
    wait_drain("t5_drain_a");
    check("t5_drop_count", DW'(drops0 - d0), DW'(1));
    check("t5_done_kept", DW'(ch0_done_buf), DW'(1));
    push_burst(1'b0, 28'h0000000);
    loaded0 = loaded0 + 16'd16;
    wait_drain("t5_drain_b");
    d1 = drops1;
    pulse(1'b0, 1'b1);
    pulse(1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1 check("t5_ch1_idle_drop", DW'(drops1 - d1), DW'(1));

    // T6: reset during DATA of ch1's second frame
    do_reset();
    pulse(1'b0, 1'b1);
    push_burst(1'b1, 28'h0400000);
    push_burst(1'b1, 28'h0400080);
    push_burst(1'b1, 28'h0400100);
    push_burst(1'b1, 28'h0400180);
    loaded1 = loaded1 + 16'd64;
    wait_drain("t6_drain");
    check("t6_done_pre", DW'(ch1_done_buf), DW'(0));
    pulse(1'b0, 1'b1);
    push_burst(1'b1, 28'h0500000);
    loaded1 = loaded1 + 16'd16;
    wait_wr_en("t6_cmd_timeout");
    @(posedge clk);
    repeat (5) @(posedge clk);
    #1 check("t6_popping", DW'(ch1_rd_en), DW'(1));
    #1 rst_n = 1'b0;
    #1;
    check("t6_rd_en", DW'({ch1_rd_en, ch0_rd_en}), DW'(0));
    check("t6_wr_en", DW'(wr_en), DW'(0));
    check("t6_wr_addr", DW'(wr_addr), DW'(0));
    check("t6_wr_id", DW'(wr_id), DW'(0));
    check("t6_done_buf", DW'({ch1_done_buf, ch0_done_buf}), DW'(2'b11));
    check("t6_drop", DW'({ch1_frame_drop, ch0_frame_drop}), DW'(0));
    check("t6_beats_left", DW'(beat_q.size()), DW'(11));
    while (beat_q.size() != 0) begin
      void'(beat_q.pop_back());
      exp_pop[1] = exp_pop[1] - 16'd1;
    end
    cmd_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1 check("t6_quiet_after_reset", DW'(wr_en), DW'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
